// File: rtl/keypad_entry.sv
// 4x4 keypad scanner with debounce; loads two 3-bit ALU operands.
// Digit keys write the selected operand; key 11 commits with a Valid pulse.
module keypad_entry #(
  parameter int CLK_DIV        = 50_000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [3:0] Col,
  output logic [3:0] Row,
  output logic [2:0] PortA,
  output logic [2:0] PortB,
  output logic       Sel,
  output logic       Valid
);

  localparam int TW = $clog2(CLK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
  localparam logic [3:0] DT = 4'(DEBOUNCE_TICKS);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD} state_t;

  state_t r_state, w_state;
  logic [3:0]    r_sync1, r_col_s;
  logic [TW-1:0] r_tick_cnt;
  logic [3:0]    r_row, w_row;
  logic [3:0]    r_pat, w_pat;
  logic [3:0]    r_cnt, w_cnt;
  logic [2:0]    r_port_a, w_port_a;
  logic [2:0]    r_port_b, w_port_b;
  logic          r_sel, w_sel;
  logic          r_valid, w_valid;
  logic          w_tick, w_idle, w_act;
  logic [2:0]    w_col_dec, w_row_dec;
  logic [3:0]    w_key;

  // {exactly-one-low, index of the low bit}
  function automatic logic [2:0] low_dec(input logic [3:0] v);
    case (v)
      4'b1110: return 3'b100;
      4'b1101: return 3'b101;
      4'b1011: return 3'b110;
      4'b0111: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  assign w_tick    = (r_tick_cnt == TICK_LAST);
  assign w_idle    = (r_col_s == 4'b1111);
  assign w_col_dec = low_dec(r_col_s);
  assign w_row_dec = low_dec(r_row);
  assign w_key     = {w_row_dec[1:0], w_col_dec[1:0]};

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_sync1    <= 4'b1111;
      r_col_s    <= 4'b1111;
      r_tick_cnt <= '0;
      r_state    <= SCAN;
      r_row      <= 4'b1110;
      r_pat      <= 4'b1111;
      r_cnt      <= 4'd0;
      r_port_a   <= 3'd0;
      r_port_b   <= 3'd0;
      r_sel      <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_sync1    <= Col;
      r_col_s    <= r_sync1;
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
      r_state    <= w_state;
      r_row      <= w_row;
      r_pat      <= w_pat;
      r_cnt      <= w_cnt;
      r_port_a   <= w_port_a;
      r_port_b   <= w_port_b;
      r_sel      <= w_sel;
      r_valid    <= w_valid;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_row    = r_row;
    w_pat    = r_pat;
    w_cnt    = r_cnt;
    w_port_a = r_port_a;
    w_port_b = r_port_b;
    w_sel    = r_sel;
    w_valid  = 1'b0;
    w_act    = 1'b0;
    if (w_tick) begin
      unique case (r_state)
        SCAN: begin
          if (w_idle) begin
            w_row = {r_row[2:0], r_row[3]};
          end else if (w_col_dec[2]) begin
            w_pat   = r_col_s;
            w_cnt   = 4'd1;
            w_state = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (w_idle) begin
            w_state = SCAN;
          end else if (!w_col_dec[2]) begin
            w_cnt = 4'd0;
          end else if (r_col_s == r_pat) begin
            w_cnt = r_cnt + 4'd1;
          end else begin
            w_pat = r_col_s;
            w_cnt = 4'd1;
          end
          if (w_col_dec[2] && w_cnt >= DT) begin
            w_act   = 1'b1;
            w_cnt   = 4'd0;
            w_state = HOLD;
          end
        end
        HOLD: begin
          if (w_idle) begin
            w_cnt = r_cnt + 4'd1;
            if (w_cnt >= DT) begin
              w_cnt   = 4'd0;
              w_state = SCAN;
            end
          end else begin
            w_cnt = 4'd0;
          end
        end
        default: w_state = SCAN;
      endcase
    end
    // Key action; the key is the live pattern, equal to the latched one here
    if (w_act) begin
      if (!w_key[3]) begin
        if (r_sel) w_port_b = w_key[2:0];
        else       w_port_a = w_key[2:0];
      end else begin
        case (w_key[2:0])
          3'd0: w_sel = 1'b0;
          3'd1: w_sel = 1'b1;
          3'd2: begin
            w_port_a = 3'd0;
            w_port_b = 3'd0;
            w_sel    = 1'b0;
          end
          3'd3: w_valid = 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign Row   = r_row;
  assign PortA = r_port_a;
  assign PortB = r_port_b;
  assign Sel   = r_sel;
  assign Valid = r_valid;

endmodule
